// File: rtl/reciprocal_divider_arbiter_pkg.sv
// Shared types for the reciprocal divider arbiter: fixed-point format and FSM state encoding.
package reciprocal_divider_arbiter_pkg;

    localparam int unsigned FIXED_W = 32;
    localparam int unsigned FRAC_W  = 16;

    typedef logic signed [FIXED_W-1:0] fixed;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESPOND
    } arb_state_t;

endpackage

// File: rtl/reciprocal_divider_arbiter_round_robin.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping.
module round_robin_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant_onehot,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    int unsigned      cand;
    logic [IDX_W-1:0] idx;

    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        any          = 1'b0;
        cand         = 0;
        idx          = '0;
        for (int unsigned off = 0; off < N; off++) begin
            if (!any) begin
                // Wrap by subtraction so non-power-of-two N needs no modulo.
                cand = 32'(ptr) + off;
                if (cand >= N) begin
                    cand = cand - N;
                end
                idx = IDX_W'(cand);
                if (req[idx]) begin
                    any               = 1'b1;
                    grant_onehot[idx] = 1'b1;
                    grant_idx         = idx;
                end
            end
        end
    end

endmodule

// File: rtl/reciprocal_divider_arbiter.sv
// Shares one reciprocal divider among NUM_REQUESTERS lanes, one division in flight.
// Optional one-entry result cache: define RECIP_DIVIDER_ARBITER_CACHE_EN.
module reciprocal_divider_arbiter
    import reciprocal_divider_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQUESTERS = 4,
    parameter int unsigned IDX_W          = $clog2(NUM_REQUESTERS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQUESTERS-1:0]       req_s_valid,
    output logic [NUM_REQUESTERS-1:0]       req_s_ready,
    input  fixed [NUM_REQUESTERS-1:0]       req_s_data,
    output logic [NUM_REQUESTERS-1:0]       resp_m_valid,
    input  logic [NUM_REQUESTERS-1:0]       resp_m_ready,
    output fixed                            resp_m_data,
    output logic                            div_s_valid,
    input  logic                            div_s_ready,
    output fixed                            div_s_data,
    input  logic                            div_m_valid,
    output logic                            div_m_ready,
    input  fixed                            div_m_data
);

    arb_state_t       state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] grant_r;
    fixed             divisor_r;
    fixed             result_r;

    logic [NUM_REQUESTERS-1:0] pick_onehot;
    logic [IDX_W-1:0]          pick_idx;
    logic                      pick_any;
    logic [IDX_W-1:0]          next_ptr;
    fixed                      pick_data;

`ifdef RECIP_DIVIDER_ARBITER_CACHE_EN
    logic cache_valid;
    fixed cache_divisor;
    fixed cache_result;
`endif

    round_robin_arbiter #(
        .N(NUM_REQUESTERS)
    ) u_rr (
        .req          (req_s_valid),
        .ptr          (rr_ptr),
        .grant_onehot (pick_onehot),
        .grant_idx    (pick_idx),
        .any          (pick_any)
    );

    assign pick_data = req_s_data[pick_idx];
    assign next_ptr  = (pick_idx == IDX_W'(NUM_REQUESTERS - 1)) ? '0 : pick_idx + 1'b1;

    assign req_s_ready = (state == IDLE) ? pick_onehot : '0;
    assign div_s_valid = (state == ISSUE);
    assign div_s_data  = divisor_r;
    assign div_m_ready = (state == WAIT);
    assign resp_m_data = result_r;

    always_comb begin
        resp_m_valid = '0;
        if (state == RESPOND) begin
            resp_m_valid[grant_r] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_r   <= '0;
            divisor_r <= '0;
            result_r  <= '0;
`ifdef RECIP_DIVIDER_ARBITER_CACHE_EN
            cache_valid   <= 1'b0;
            cache_divisor <= '0;
            cache_result  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant_r   <= pick_idx;
                        divisor_r <= pick_data;
                        rr_ptr    <= next_ptr;
`ifdef RECIP_DIVIDER_ARBITER_CACHE_EN
                        // A repeat of the last divisor skips the divider entirely.
                        if (cache_valid && (cache_divisor == pick_data)) begin
                            result_r <= cache_result;
                            state    <= RESPOND;
                        end else begin
                            state <= ISSUE;
                        end
`else
                        state <= ISSUE;
`endif
                    end
                end
                ISSUE: begin
                    if (div_s_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (div_m_valid) begin
                        result_r <= div_m_data;
                        state    <= RESPOND;
`ifdef RECIP_DIVIDER_ARBITER_CACHE_EN
                        cache_valid   <= 1'b1;
                        cache_divisor <= divisor_r;
                        cache_result  <= div_m_data;
`endif
                    end
                end
                RESPOND: begin
                    if (resp_m_ready[grant_r]) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reciprocal_divider_arbiter.sv
// Directed bench for reciprocal_divider_arbiter; the bench plays the divider (Q16.16 values).
module tb_reciprocal_divider_arbiter;
    import reciprocal_divider_arbiter_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] req_s_valid;
    logic [3:0] req_s_ready;
    fixed [3:0] req_s_data;
    logic [3:0] resp_m_valid;
    logic [3:0] resp_m_ready;
    fixed       resp_m_data;
    logic       div_s_valid;
    logic       div_s_ready;
    fixed       div_s_data;
    logic       div_m_valid;
    logic       div_m_ready;
    fixed       div_m_data;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned gcount [4];

    reciprocal_divider_arbiter #(
        .NUM_REQUESTERS(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_s_valid  (req_s_valid),
        .req_s_ready  (req_s_ready),
        .req_s_data   (req_s_data),
        .resp_m_valid (resp_m_valid),
        .resp_m_ready (resp_m_ready),
        .resp_m_data  (resp_m_data),
        .div_s_valid  (div_s_valid),
        .div_s_ready  (div_s_ready),
        .div_s_data   (div_s_data),
        .div_m_valid  (div_m_valid),
        .div_m_ready  (div_m_ready),
        .div_m_data   (div_m_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one full transaction for `lane`; caller has already raised the lane's valid/data.
    task automatic serve(input int unsigned lane, input logic [31:0] dv, input logic [31:0] res,
                         input int unsigned lat, input int unsigned istall, input int unsigned rstall,
                         input bit keep, input logic [3:0] extra);
        logic [3:0] oh;
        oh = 4'(1) << lane;
        #1;
        chk("grant_ready", 32'(req_s_ready), 32'(oh));
        chk("idle_div_valid", 32'(div_s_valid), 32'd0);
        for (int unsigned i = 0; i < 4; i++) if (req_s_ready[i]) gcount[i]++;
        @(negedge clk);
        if (!keep) req_s_valid[lane] = 1'b0;
        #1;
        chk("issue_ready_clear", 32'(req_s_ready), 32'd0);
        chk("issue_valid", 32'(div_s_valid), 32'd1);
        chk("issue_data", div_s_data, dv);
        for (int unsigned s = 0; s < istall; s++) begin
            @(negedge clk); #1;
            chk("stall_valid", 32'(div_s_valid), 32'd1);
            chk("stall_data", div_s_data, dv);
        end
        div_s_ready = 1'b1;
        @(negedge clk);
        div_s_ready = 1'b0;
        #1;
        chk("wait_mready", 32'(div_m_ready), 32'd1);
        chk("wait_svalid", 32'(div_s_valid), 32'd0);
        for (int unsigned s = 0; s < lat; s++) @(negedge clk);
        div_m_valid = 1'b1;
        div_m_data  = res;
        @(negedge clk);
        div_m_valid = 1'b0;
        div_m_data  = '0;
        req_s_valid = req_s_valid | extra;
        #1;
        chk("resp_valid", 32'(resp_m_valid), 32'(oh));
        chk("resp_data", resp_m_data, res);
        chk("resp_mready", 32'(div_m_ready), 32'd0);
        for (int unsigned s = 0; s < rstall; s++) begin
            @(negedge clk); #1;
            chk("rstall_valid", 32'(resp_m_valid), 32'(oh));
            chk("rstall_no_ready", 32'(req_s_ready), 32'd0);
        end
        resp_m_ready = oh;
        @(negedge clk);
        resp_m_ready = '0;
        #1;
        chk("done_resp_clear", 32'(resp_m_valid), 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        req_s_valid  = '0;
        req_s_data   = '0;
        resp_m_ready = '0;
        div_s_ready  = 1'b0;
        div_m_valid  = 1'b0;
        div_m_data   = '0;
        for (int i = 0; i < 4; i++) gcount[i] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_s_ready), 32'd0);
        chk("rst_div_valid", 32'(div_s_valid), 32'd0);
        chk("rst_div_data", div_s_data, 32'd0);
        chk("rst_mready", 32'(div_m_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_m_valid), 32'd0);
        chk("rst_resp_data", resp_m_data, 32'd0);

        // Single lane 1: 8.0 -> 0.125
        @(negedge clk);
        req_s_valid[1] = 1'b1; req_s_data[1] = 32'h0008_0000;
        serve(1, 32'h0008_0000, 32'h0000_2000, 2, 0, 0, 0, 4'b0000);

        // Re-reset to bring rr_ptr back to 0
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;

        // Lanes 0,2,3 together: order 0,2,3
        req_s_valid = 4'b1101;
        req_s_data[0] = 32'h0002_0000;
        req_s_data[2] = 32'h0010_0000;
        req_s_data[3] = 32'h0000_8000;
        serve(0, 32'h0002_0000, 32'h0000_8000, 1, 0, 0, 0, 4'b0000);
        serve(2, 32'h0010_0000, 32'h0000_1000, 1, 0, 0, 0, 4'b0000);
        serve(3, 32'h0000_8000, 32'h0002_0000, 1, 0, 0, 0, 4'b0000);
        // Lanes 0 and 3 with rr_ptr back at 0: 0 then 3
        req_s_valid = 4'b1001;
        serve(0, 32'h0002_0000, 32'h0000_8000, 1, 0, 0, 0, 4'b0000);
        serve(3, 32'h0000_8000, 32'h0002_0000, 1, 0, 0, 0, 4'b0000);

        // Back-pressure on lane 2; lane 0 raises valid while the response is held
        req_s_valid[2] = 1'b1; req_s_data[2] = 32'h0001_0000;
        serve(2, 32'h0001_0000, 32'h0001_0000, 1, 5, 4, 0, 4'b0001);
        serve(0, 32'h0002_0000, 32'h0000_8000, 1, 0, 0, 0, 4'b0000);

        // Reset during WAIT abandons the division
        req_s_valid[1] = 1'b1; req_s_data[1] = 32'h0008_0000;
        #1;
        chk("rw_grant", 32'(req_s_ready), 32'b0010);
        @(negedge clk);
        req_s_valid[1] = 1'b0;
        div_s_ready = 1'b1;
        @(negedge clk);
        div_s_ready = 1'b0;
        #1;
        chk("rw_in_wait", 32'(div_m_ready), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rw_req_ready", 32'(req_s_ready), 32'd0);
        chk("rw_div_valid", 32'(div_s_valid), 32'd0);
        chk("rw_div_data", div_s_data, 32'd0);
        chk("rw_mready", 32'(div_m_ready), 32'd0);
        chk("rw_resp_valid", 32'(resp_m_valid), 32'd0);
        chk("rw_resp_data", resp_m_data, 32'd0);
        div_m_valid = 1'b1; div_m_data = 32'h0000_1234;
        #1;
        chk("late_mready", 32'(div_m_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            div_m_valid = 1'b0; div_m_data = '0;
            #1;
            chk("late_no_resp", 32'(resp_m_valid), 32'd0);
            chk("late_no_data", resp_m_data, 32'd0);
        end
        @(negedge clk);
        req_s_valid[3] = 1'b1; req_s_data[3] = 32'h0000_8000;
        serve(3, 32'h0000_8000, 32'h0002_0000, 0, 0, 0, 0, 4'b0000);

        // All four lanes valid continuously for 40 grants
        for (int i = 0; i < 4; i++) gcount[i] = 0;
        req_s_data[0] = 32'h0002_0000;
        req_s_data[1] = 32'h0008_0000;
        req_s_data[2] = 32'h0010_0000;
        req_s_data[3] = 32'h0001_0000;
        req_s_valid = 4'b1111;
        for (int k = 0; k < 40; k++) begin
            case (k % 4)
                0: serve(0, 32'h0002_0000, 32'h0000_8000, 0, 0, 0, 1, 4'b0000);
                1: serve(1, 32'h0008_0000, 32'h0000_2000, 0, 0, 0, 1, 4'b0000);
                2: serve(2, 32'h0010_0000, 32'h0000_1000, 0, 0, 0, 1, 4'b0000);
                default: serve(3, 32'h0001_0000, 32'h0001_0000, 0, 0, 0, 1, 4'b0000);
            endcase
        end
        req_s_valid = '0;
        chk("fair_lane0", gcount[0], 32'd10);
        chk("fair_lane1", gcount[1], 32'd10);
        chk("fair_lane2", gcount[2], 32'd10);
        chk("fair_lane3", gcount[3], 32'd10);

        // Same divisor 4.0 twice on lane 1
        @(negedge clk);
        req_s_valid[1] = 1'b1; req_s_data[1] = 32'h0004_0000;
        serve(1, 32'h0004_0000, 32'h0000_4000, 1, 0, 0, 0, 4'b0000);
        req_s_valid[1] = 1'b1;
`ifdef RECIP_DIVIDER_ARBITER_CACHE_EN
        #1;
        chk("cache_grant", 32'(req_s_ready), 32'b0010);
        @(negedge clk);
        req_s_valid[1] = 1'b0;
        #1;
        chk("cache_resp_valid", 32'(resp_m_valid), 32'b0010);
        chk("cache_resp_data", resp_m_data, 32'h0000_4000);
        chk("cache_no_div", 32'(div_s_valid), 32'd0);
        resp_m_ready = 4'b0010;
        @(negedge clk);
        resp_m_ready = '0;
        #1;
        chk("cache_done", 32'(resp_m_valid), 32'd0);
        chk("cache_no_div_after", 32'(div_s_valid), 32'd0);
`else
        serve(1, 32'h0004_0000, 32'h0000_4000, 1, 0, 0, 0, 4'b0000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reciprocal_divider_arbiter.md
Name: reciprocal_divider_arbiter

Overview:
- Shares one FixedReciprocalDivider instance between NUM_REQUESTERS triangle preprocessors so several preprocessor lanes can run without one divider per lane.
- Round-robin arbitration; one division in flight at a time.
- Each result returns on the response channel of the requester that issued the divisor.
- Sits between the preprocessor lanes' divisor/result streams and the divider's divisor_s_*/result_m_* ports.

Parameters:
- NUM_REQUESTERS, 4, number of requester lanes (2..8).
- IDX_W, $clog2(NUM_REQUESTERS), grant index width (derived; do not override).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_s_valid  in  [NUM_REQUESTERS]  divisor valid per lane
- req_s_ready  out  [NUM_REQUESTERS]  divisor accepted per lane
- req_s_data  in  [NUM_REQUESTERS] x fixed  divisor (area) per lane
- resp_m_valid  out  [NUM_REQUESTERS]  reciprocal valid per lane
- resp_m_ready  in  [NUM_REQUESTERS]  lane ready for reciprocal
- resp_m_data  out  fixed  reciprocal; shared bus, qualified by resp_m_valid
- div_s_valid  out  1  to divider divisor_s_valid
- div_s_ready  in  1  from divider divisor_s_ready
- div_s_data  out  fixed  to divider divisor_s_data
- div_m_valid  in  1  from divider result_m_valid
- div_m_ready  out  1  to divider result_m_ready
- div_m_data  in  fixed  from divider result_m_data

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, rr_ptr=0, grant_r=0, divisor_r=0, result_r=0.
  - All valid/ready outputs are 0; resp_m_data=0.
  - Reset mid-operation abandons the in-flight division. The divider shares rst and is cleared with it.
- States:
  - IDLE: accept one request.
  - ISSUE: present divisor to divider.
  - WAIT: await divider result.
  - RESPOND: deliver result to the owning lane.
- IDLE:
  - Combinational round-robin pick: the first lane with req_s_valid=1, searching from rr_ptr upward with wrap.
  - req_s_ready[i]=1 only for the picked lane, only in IDLE. At most one bit of req_s_ready is set.
  - On handshake: grant_r<=i, divisor_r<=req_s_data[i], rr_ptr<=(i+1) mod NUM_REQUESTERS, go to ISSUE.
  - No valid request: stay in IDLE, rr_ptr unchanged.
- ISSUE:
  - div_s_valid=1, div_s_data=divisor_r.
  - Leave for WAIT on div_s_valid&&div_s_ready.
  - div_s_valid is held, with data stable, until accepted.
- WAIT:
  - div_m_ready=1.
  - On div_m_valid: result_r<=div_m_data, go to RESPOND.
  - div_m_ready=0 in every other state.
- RESPOND:
  - resp_m_valid[grant_r]=1, resp_m_data=result_r.
  - On resp_m_ready[grant_r]: go to IDLE.
  - Other lanes' resp_m_ready is ignored.
- Latency: handshake at cycle 0 → ISSUE at cycle 1 → resp_m_valid at cycle (2 + divider latency + 1) minimum.
- Back-to-back: a new request is accepted only in the IDLE cycle following the response handshake. The block makes no claim of full throughput.
- Simultaneous requests: exactly one is granted per IDLE visit. A lane holding valid is served within NUM_REQUESTERS grants (starvation-free).
- Lanes must hold req_s_valid/req_s_data until ready (AXI-stream rule). A lane that drops valid before the grant simply loses its turn.
- Zero divisor: passed through unchanged; the divider defines the result.
- No arithmetic inside the arbiter except rr_ptr wrap.

Optional Feature:
- Macro: RECIP_DIVIDER_ARBITER_CACHE_EN
- Defined: adds a one-entry cache {cache_valid, cache_divisor, cache_result}.
  - Cleared by rst.
  - Filled on every WAIT→RESPOND transition.
  - In IDLE, if the accepted divisor equals cache_divisor and cache_valid=1: result_r<=cache_result and go directly to RESPOND. resp_m_valid is asserted the cycle after acceptance; the divider is not touched.
  - Exposes no extra ports.
- Undefined: no cache storage; every request goes through ISSUE/WAIT.

Decomposition:
- In types_pkg: typedef enum arb_state_t {IDLE, ISSUE, WAIT, RESPOND}.
- fixed comes from fixed_pkg.
- Sub-module: round_robin_arbiter (params N; inputs req[N], ptr; outputs grant_onehot[N], grant_idx, any). Purely combinational, reusable by later rasterizer dispatch.

Test Plan:
- Single lane 1, divisor 8.0: req_s_ready[1] on cycle 0; div_s_data=8.0; divider returns 0.125; resp_m_valid[1]=1 with data 0.125, all other resp_m_valid=0.
- Lanes 0,2,3 valid together, rr_ptr=0: grants in order 0,2,3. Then lane 0 and 3 valid with rr_ptr=0: lane 0 is granted first, then lane 3.
- Back-pressure: hold div_s_ready=0 for 5 cycles → div_s_valid stays 1 with stable data. Hold resp_m_ready[2]=0 for 4 cycles → resp_m_valid[2] stays 1 and no new req_s_ready is asserted.
- Assert rst during WAIT: the next cycle has all outputs 0 and state IDLE. A late div_m_valid then is ignored (div_m_ready=0) and produces no response.
- All lanes valid continuously for 40 requests: each lane gets exactly 10 grants. No two req_s_ready bits or resp_m_valid bits are ever set together.
- With RECIP_DIVIDER_ARBITER_CACHE_EN: divisor 4.0 twice in a row → second response arrives 1 cycle after acceptance with data 0.25 and div_s_valid never asserted. Same test without the macro: both requests hit the divider.
